// File: rtl/peb_flg_gather.sv
// peb_flg_gather: gathers BEATS words per PEB lane, in ascending lane order, into one registered upstream stream.
module peb_flg_gather #(
  parameter int PEB = 16,
  parameter int DW = 32,
  parameter int BEATS = 14,
  localparam int IW = (PEB > 1) ? $clog2(PEB) : 1,
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PEB-1:0]    peb_val,
  input  logic [PEB*DW-1:0] peb_dat,
  output logic [PEB-1:0]    peb_rdy,
  output logic              out_val,
  output logic [DW-1:0]     out_dat,
  output logic [IW-1:0]     out_idx,
  input  logic              out_rdy,
  output logic              busy,
  output logic              frame_done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t        state_q;
  logic [BW-1:0] beat_q, beat_d;
  logic [IW-1:0] lane_q, lane_d, out_idx_q;
  logic [DW-1:0] out_dat_q, sel_dat;
  logic          out_val_q, done_q;
  logic          run, slot_free, acc, leave, last_beat, last_lane;
  assign run       = state_q == RUN;
  assign slot_free = ~out_val_q | out_rdy;
  assign acc       = run & peb_val[lane_q] & slot_free;
  assign leave     = out_val_q & out_rdy;
  assign last_beat = beat_q == BW'(BEATS - 1);
  assign last_lane = lane_q == IW'(PEB - 1);
  assign beat_d    = last_beat ? '0 : beat_q + 1'b1;
  assign lane_d    = !last_beat ? lane_q : last_lane ? '0 : lane_q + 1'b1;
  // only the selected lane is muxed out, so unselected lanes never reach the register
  assign sel_dat   = peb_dat[lane_q*DW +: DW];
  assign peb_rdy   = (run & slot_free) ? PEB'(1) << lane_q : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      lane_q    <= '0;
      out_val_q <= 1'b0;
      out_dat_q <= '0;
      out_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (acc) begin
        out_val_q <= 1'b1;
        out_dat_q <= sel_dat;
        out_idx_q <= lane_q;
        beat_q    <= beat_d;
        lane_q    <= lane_d;
      end else if (leave) begin
        out_val_q <= 1'b0;
      end
      case (state_q)
        IDLE:    if (start) state_q <= RUN;
        RUN:     if (acc && last_beat && last_lane) state_q <= DRAIN;
        DRAIN:   if (leave) begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign out_val    = out_val_q;
  assign out_dat    = out_dat_q;
  assign out_idx    = out_idx_q;
  assign busy       = state_q != IDLE;
  assign frame_done = done_q;
endmodule
